refresh_timer_multi: RTL and testbench

Multi-channel programmable refresh timer, the parametrised successor to the fixed 500 ms refresh tick. A shared prescaler derives a base tick from the system clock, and N_CH independent channel counters count base ticks. Each channel emits a one-cycle pulse when its run-time-loadable period elapses. It feeds display multiplexing, debounce sampling and LED blink logic from one block.

---
 rtl/refresh_pkg.sv | 30 +++
 rtl/refresh_prescaler.sv | 46 ++++
 rtl/refresh_timer_multi.sv | 144 ++++++++++++++
 tb/tb_refresh_timer_multi.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/refresh_pkg.sv
// refresh_pkg: shared constants, helpers and load-command payload for the
// multi-channel refresh timer.
//   presc_calc(clk_hz, tick_us) : system-clock cycles per base tick
//   DEF_*                       : default parameter values of the timer
//   ld_cmd_t                    : period-load command {channel, period}
package refresh_pkg;

  localparam int unsigned DEF_CLK_HZ  = 100_000_000;
  localparam int unsigned DEF_TICK_US = 1000;
  localparam int unsigned DEF_N_CH    = 4;
  localparam int unsigned DEF_CNT_W   = 16;
  localparam int unsigned DEF_PERIOD  = 500;

  // Command fields are sized for the largest supported configuration; the
  // timer narrows them with explicit casts.
  localparam int unsigned CMD_CH_W     = 16;
  localparam int unsigned CMD_PERIOD_W = 32;

  typedef struct packed {
    logic [CMD_CH_W-1:0]     ch;
    logic [CMD_PERIOD_W-1:0] period;
  } ld_cmd_t;

  // Clock cycles per base tick; the result must be at least 2.
  function automatic int unsigned presc_calc(input int unsigned clk_hz,
                                             input int unsigned tick_us);
    return (clk_hz / 1_000_000) * tick_us;
  endfunction

endpackage

// File: rtl/refresh_prescaler.sv
// refresh_prescaler: free-running divider producing the shared base tick.
//   clk, rst  : clock, synchronous active-high reset
//   en        : run enable; low freezes the divider and suppresses base_tick
//   base_tick : registered one-cycle pulse every PRESC enabled cycles
// PRESC must be at least 2.
module refresh_prescaler #(
  parameter int unsigned PRESC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic base_tick
);

  localparam int unsigned P_W = (PRESC > 1) ? $clog2(PRESC) : 1;

  logic [P_W-1:0] p_q, p_d;
  logic           base_tick_q, base_tick_d;

  // Divider next state; the pulse is raised on the wrap edge.
  always_comb begin
    p_d         = p_q;
    base_tick_d = 1'b0;
    if (en) begin
      if (p_q == P_W'(PRESC - 1)) begin
        p_d         = '0;
        base_tick_d = 1'b1;
      end else begin
        p_d = p_q + P_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q         <= '0;
      base_tick_q <= 1'b0;
    end else begin
      p_q         <= p_d;
      base_tick_q <= base_tick_d;
    end
  end

  assign base_tick = base_tick_q;

endmodule

// File: rtl/refresh_timer_multi.sv
// refresh_timer_multi: shared prescaler plus N_CH programmable period
// counters, each emitting a one-cycle tick when its period elapses.
//   clk, rst   : clock, synchronous active-high reset
//   en         : global run (freezes prescaler, hence all channels)
//   ch_run     : per-channel run; low holds that channel's count
//   ld_valid / ld_ready / ld_ch / ld_period : period-load handshake;
//                period 0 disables a channel, ld_ch >= N_CH is discarded
//   base_tick  : one-cycle pulse every PRESC enabled cycles
//   tick       : per-channel expiry pulses
//   sq         : per-channel square waves (only with REFRESH_SQ_OUT_EN)
// Optional feature macro: REFRESH_SQ_OUT_EN.
module refresh_timer_multi
  import refresh_pkg::*;
#(
  parameter  int unsigned CLK_HZ         = DEF_CLK_HZ,
  parameter  int unsigned TICK_US        = DEF_TICK_US,
  parameter  int unsigned N_CH           = DEF_N_CH,
  parameter  int unsigned CNT_W          = DEF_CNT_W,
  parameter  int unsigned DEFAULT_PERIOD = DEF_PERIOD,
  localparam int unsigned LD_CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [N_CH-1:0]    ch_run,
  input  logic               ld_valid,
  input  logic [LD_CH_W-1:0] ld_ch,
  input  logic [CNT_W-1:0]   ld_period,
  output logic               ld_ready,
  output logic               base_tick,
  output logic [N_CH-1:0]    tick
`ifdef REFRESH_SQ_OUT_EN
  ,
  output logic [N_CH-1:0]    sq
`endif
);

  localparam int unsigned PRESC = presc_calc(CLK_HZ, TICK_US);

  refresh_prescaler #(
    .PRESC (PRESC)
  ) u_presc (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .base_tick (base_tick)
  );

  ld_cmd_t ld_cmd;
  logic    ld_fire;
  logic    ld_hit;
  logic    ld_ready_q, ld_ready_d;

  assign ld_cmd.ch     = CMD_CH_W'(ld_ch);
  assign ld_cmd.period = CMD_PERIOD_W'(ld_period);

  // Out-of-range channels still complete the handshake but write nothing.
  assign ld_fire = ld_valid && ld_ready_q;
  assign ld_hit  = ld_fire && (32'(ld_cmd.ch) < N_CH);

  // Ready drops for exactly one cycle after each accepted transfer.
  always_comb begin
    ld_ready_d = 1'b1;
    if (ld_fire) begin
      ld_ready_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_ready_q <= 1'b0;
    end else begin
      ld_ready_q <= ld_ready_d;
    end
  end

  assign ld_ready = ld_ready_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic             tick_q, tick_d;
    logic             sel;

    assign sel = ld_hit && (ld_cmd.ch == CMD_CH_W'(i));

    // A load beats a coincident base tick: count restarts, no tick issued.
    always_comb begin
      cnt_d  = cnt_q;
      per_d  = per_q;
      tick_d = 1'b0;
      if (sel) begin
        per_d = CNT_W'(ld_cmd.period);
        cnt_d = '0;
      end else if (base_tick && ch_run[i] && (per_q != '0)) begin
        if (cnt_q == per_q - CNT_W'(1)) begin
          cnt_d  = '0;
          tick_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q  <= '0;
        per_q  <= CNT_W'(DEFAULT_PERIOD);
        tick_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        per_q  <= per_d;
        tick_q <= tick_d;
      end
    end

    assign tick[i] = tick_q;

`ifdef REFRESH_SQ_OUT_EN
    logic sq_q, sq_d;

    // Toggle one edge after each tick; a load to this channel restarts low.
    always_comb begin
      sq_d = sq_q;
      if (sel) begin
        sq_d = 1'b0;
      end else if (tick_q) begin
        sq_d = ~sq_q;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        sq_q <= 1'b0;
      end else begin
        sq_q <= sq_d;
      end
    end

    assign sq[i] = sq_q;
`endif
  end

endmodule

// File: tb/tb_refresh_timer_multi.sv
// Bench for refresh_timer_multi at PRESC=4, N_CH=4, DEFAULT_PERIOD=3, with a
// second N_CH=3 instance used for out-of-range load discards.
module tb_refresh_timer_multi;

  localparam int unsigned PRESC = 4;
  localparam int unsigned NCH   = 4;
  localparam int unsigned DEFP  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [3:0]  ch_run = '0;
  logic        ld_valid = 1'b0;
  logic [1:0]  ld_ch = '0;
  logic [15:0] ld_period = '0;
  logic        ld_ready, base_tick;
  logic [3:0]  tick;
  logic        ld_ready3, base_tick3;
  logic [2:0]  tick3;
`ifdef REFRESH_SQ_OUT_EN
  logic [3:0]  sq;
  logic [2:0]  sq3;
`endif

  int total = 0;
  int bad = 0;
  int edge_n = 0;

  always #5 clk = ~clk;

  refresh_timer_multi #(
    .CLK_HZ(1_000_000), .TICK_US(4), .N_CH(4), .CNT_W(16), .DEFAULT_PERIOD(3)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .ch_run(ch_run), .ld_valid(ld_valid),
    .ld_ch(ld_ch), .ld_period(ld_period), .ld_ready(ld_ready),
    .base_tick(base_tick), .tick(tick)
`ifdef REFRESH_SQ_OUT_EN
    , .sq(sq)
`endif
  );

  refresh_timer_multi #(
    .CLK_HZ(1_000_000), .TICK_US(4), .N_CH(3), .CNT_W(16), .DEFAULT_PERIOD(3)
  ) dut3 (
    .clk(clk), .rst(rst), .en(en), .ch_run(ch_run[2:0]), .ld_valid(ld_valid),
    .ld_ch(ld_ch), .ld_period(ld_period), .ld_ready(ld_ready3),
    .base_tick(base_tick3), .tick(tick3)
`ifdef REFRESH_SQ_OUT_EN
    , .sq(sq3)
`endif
  );

  // Behavioural model: prescaler phase from a count of enabled edges,
  // channels as base-tick tallies against their period.
  int m_en_edges;
  bit m_bt, m_rdy;
  int m_cnt [NCH];
  int m_per [NCH];
  bit m_tick [NCH];
  bit m_sq [NCH];
  bit t_old [NCH];

  task automatic model_update();
    bit acc, bt_old;
    if (rst) begin
      m_en_edges = 0; m_bt = 0; m_rdy = 0;
      for (int i = 0; i < NCH; i++) begin
        m_cnt[i] = 0; m_per[i] = DEFP; m_tick[i] = 0; m_sq[i] = 0;
      end
    end else begin
      acc = ld_valid && m_rdy;
      bt_old = m_bt;
      for (int i = 0; i < NCH; i++) begin
        t_old[i] = m_tick[i];
        m_tick[i] = 0;
        if (acc && int'(ld_ch) == i) begin
          m_per[i] = int'(ld_period); m_cnt[i] = 0; m_sq[i] = 0;
        end else begin
          if (bt_old && ch_run[i] && m_per[i] != 0) begin
            m_cnt[i]++;
            if (m_cnt[i] >= m_per[i]) begin
              m_cnt[i] = 0; m_tick[i] = 1;
            end
          end
          if (t_old[i]) m_sq[i] = !m_sq[i];
        end
      end
      if (en) begin
        m_en_edges++;
        m_bt = (m_en_edges % PRESC == 0);
      end else begin
        m_bt = 0;
      end
      m_rdy = !acc;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    edge_n++;
  endtask

  task automatic restart();
    rst = 1'b1; ld_valid = 1'b0;
    step();
    rst = 1'b0; en = 1'b1; ch_run = 4'hF;
    edge_n = 0;
  endtask

  // Default period 3 from reset: all channels tick after edges 13, 25, 37...
  function automatic bit dflt_tick(input int e);
    return (e >= 13) && ((e - 13) % 12 == 0);
  endfunction

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; ch_run = 4'hF; ld_valid = 1'b0;
    step(); step();
    total++;
    if (base_tick !== 1'b0 || tick !== 4'h0 || ld_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs got bt=%b tick=%b rdy=%b exp 0 0000 0", base_tick, tick, ld_ready);
    end
    total++;
    if (base_tick3 !== 1'b0 || tick3 !== 3'h0 || ld_ready3 !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs3 got bt=%b tick=%b rdy=%b exp 0 000 0", base_tick3, tick3, ld_ready3);
    end
`ifdef REFRESH_SQ_OUT_EN
    total++;
    if (sq !== 4'h0) begin
      bad++;
      $display("FAIL reset_sq got=%b exp=0000", sq);
    end
`endif
  endtask

  task automatic test_cadence();
    logic [3:0] et;
    rst = 1'b0; edge_n = 0;
    step();
    total++;
    if (ld_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_release got=%b exp=1", ld_ready);
    end
    for (int k = 0; k < 40; k++) begin
      total++;
      if (base_tick !== (edge_n % PRESC == 0)) begin
        bad++;
        $display("FAIL cadence_base_tick edge=%0d got=%b exp=%b", edge_n, base_tick, (edge_n % PRESC == 0));
      end
      et = dflt_tick(edge_n) ? 4'hF : 4'h0;
      total++;
      if (tick !== et) begin
        bad++;
        $display("FAIL cadence_tick edge=%0d got=%b exp=%b", edge_n, tick, et);
      end
      step();
    end
  endtask

  task automatic test_load_period1();
    logic [3:0] et;
    restart();
    step();
    ld_valid = 1'b1; ld_ch = 2'd1; ld_period = 16'd1;
    step();
    ld_valid = 1'b0;
    for (int k = 0; k < 46; k++) begin
      step();
      et = dflt_tick(edge_n) ? 4'b1101 : 4'b0000;
      if (edge_n >= 5 && edge_n % 4 == 1) et[1] = 1'b1;
      total++;
      if (tick !== et) begin
        bad++;
        $display("FAIL load_period1 edge=%0d got=%b exp=%b", edge_n, tick, et);
      end
    end
  endtask

  task automatic test_period0();
    logic [3:0] et;
    restart();
    step();
    ld_valid = 1'b1; ld_ch = 2'd2; ld_period = 16'd0;
    step();
    ld_valid = 1'b0;
    for (int k = 0; k < 100; k++) begin
      step();
      et = dflt_tick(edge_n) ? 4'b1011 : 4'b0000;
      total++;
      if (tick !== et) begin
        bad++;
        $display("FAIL period0 edge=%0d got=%b exp=%b", edge_n, tick, et);
      end
    end
  endtask

  task automatic test_run_hold();
    logic [3:0] et;
    restart();
    while (edge_n < 6) step();
    ch_run[0] = 1'b0;
    repeat (8) step();
    ch_run[0] = 1'b1;
    while (edge_n < 50) begin
      step();
      et = dflt_tick(edge_n) ? 4'b1110 : 4'b0000;
      if (edge_n >= 21 && (edge_n - 21) % 12 == 0) et[0] = 1'b1;
      total++;
      if (tick !== et) begin
        bad++;
        $display("FAIL run_hold edge=%0d got=%b exp=%b", edge_n, tick, et);
      end
    end
  endtask

  task automatic test_load_collision();
    logic [3:0] et;
    restart();
    while (edge_n < 12) step();
    ld_valid = 1'b1; ld_ch = 2'd3; ld_period = 16'd3;
    step();
    ld_valid = 1'b0;
    total++;
    if (tick !== 4'b0111 || ld_ready !== 1'b0) begin
      bad++;
      $display("FAIL collision_edge got tick=%b rdy=%b exp 0111 0", tick, ld_ready);
    end
    while (edge_n < 40) begin
      step();
      et = dflt_tick(edge_n) ? 4'hF : 4'h0;
      total++;
      if (tick !== et) begin
        bad++;
        $display("FAIL collision_after edge=%0d got=%b exp=%b", edge_n, tick, et);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] seen;
    logic [3:0] exp_seen;
    restart();
    step(); step();
    seen[0] = ld_ready;
    ld_valid = 1'b1; ld_ch = 2'd0; ld_period = 16'd3;
    step(); seen[1] = ld_ready;
    step(); seen[2] = ld_ready;
    step(); seen[3] = ld_ready;
    ld_valid = 1'b0;
    exp_seen = 4'b0101;
    total++;
    if (seen !== exp_seen) begin
      bad++;
      $display("FAIL back_to_back_ready got=%b exp=%b (bit0 first)", seen, exp_seen);
    end
  endtask

  task automatic test_discard();
    logic [2:0] et;
    restart();
    step();
    ld_valid = 1'b1; ld_ch = 2'd3; ld_period = 16'd1;
    step();
    ld_valid = 1'b0;
    total++;
    if (ld_ready3 !== 1'b0) begin
      bad++;
      $display("FAIL discard_handshake got=%b exp=0", ld_ready3);
    end
    while (edge_n < 26) begin
      step();
      et = dflt_tick(edge_n) ? 3'b111 : 3'b000;
      total++;
      if (tick3 !== et) begin
        bad++;
        $display("FAIL discard_ticks edge=%0d got=%b exp=%b", edge_n, tick3, et);
      end
    end
  endtask

  task automatic test_reset_mid();
    restart();
    while (edge_n < 24) step();
    rst = 1'b1;
    step();
    total++;
    if (tick !== 4'h0 || base_tick !== 1'b0 || ld_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid got tick=%b bt=%b rdy=%b exp 0000 0 0", tick, base_tick, ld_ready);
    end
`ifdef REFRESH_SQ_OUT_EN
    total++;
    if (sq !== 4'h0) begin
      bad++;
      $display("FAIL reset_mid_sq got=%b exp=0000", sq);
    end
`endif
    rst = 1'b0;
  endtask

`ifdef REFRESH_SQ_OUT_EN
  task automatic test_sq();
    logic [3:0] es;
    restart();
    while (edge_n < 60) begin
      step();
      es = (edge_n >= 14 && ((edge_n - 14) / 12) % 2 == 0) ? 4'hF : 4'h0;
      total++;
      if (sq !== es) begin
        bad++;
        $display("FAIL sq_wave edge=%0d got=%b exp=%b", edge_n, sq, es);
      end
    end
  endtask
`endif

  task automatic test_random();
    logic [3:0] et;
    logic [3:0] es;
    restart();
    for (int k = 0; k < 1500; k++) begin
      rst = ($urandom_range(0, 299) == 0);
      en = ($urandom_range(0, 7) != 0);
      ch_run = 4'($urandom) | 4'($urandom);
      ld_valid = ($urandom_range(0, 5) == 0);
      ld_ch = 2'($urandom);
      ld_period = 16'($urandom_range(0, 4));
      step();
      for (int i = 0; i < NCH; i++) begin
        et[i] = m_tick[i];
        es[i] = m_sq[i];
      end
      total++;
      if (tick !== et || base_tick !== m_bt || ld_ready !== m_rdy) begin
        bad++;
        $display("FAIL random k=%0d got tick=%b bt=%b rdy=%b exp tick=%b bt=%b rdy=%b",
                 k, tick, base_tick, ld_ready, et, m_bt, m_rdy);
      end
`ifdef REFRESH_SQ_OUT_EN
      total++;
      if (sq !== es) begin
        bad++;
        $display("FAIL random_sq k=%0d got=%b exp=%b", k, sq, es);
      end
`else
      es = '0;
`endif
    end
    rst = 1'b0; ld_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cadence();
    test_load_period1();
    test_period0();
    test_run_hold();
    test_load_collision();
    test_back_to_back();
    test_discard();
`ifdef REFRESH_SQ_OUT_EN
    test_sq();
`endif
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
